// File: rtl/servo_pwm_ramp.sv
// Servo PWM generator with slew limiting.
// Produces a fixed-period pulse train whose high time follows a clamped
// target width, moving toward it by at most STEP_US per frame.
module servo_pwm_ramp #(
    parameter int unsigned CLK_MHZ  = 100,
    parameter int unsigned FRAME_US = 20000,
    parameter int unsigned MIN_US   = 500,
    parameter int unsigned MAX_US   = 2500,
    parameter int unsigned STEP_US  = 10
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] pulse_len,
    output logic        CONTROL_PIN,
    output logic [15:0] current_len,
    output logic        frame_start,
    output logic        at_target
);

    localparam int unsigned PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam int unsigned CW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_MHZ - 1);
    localparam logic [CW-1:0] US_LAST   = CW'(FRAME_US - 1);
    localparam logic [15:0]   MIN_LEN   = 16'(MIN_US);
    localparam logic [15:0]   MAX_LEN   = 16'(MAX_US);
    localparam logic [15:0]   RST_LEN   = 16'((MIN_US + MAX_US) / 2);
    localparam logic [15:0]   STEP_LEN  = 16'(STEP_US);
    localparam logic [16:0]   STEP_DIFF = 17'(STEP_US);

    logic [PW-1:0] prescaler;
    logic [CW-1:0] us_count;
    logic          us_tick;
    logic          boundary;
    logic [15:0]   tgt;
    logic [16:0]   diff;
    logic [15:0]   next_len;

    assign us_tick  = (prescaler == PRE_LAST);
    assign boundary = us_tick && (us_count == US_LAST);

    // Clamp the requested width into the safe servo range
    always_comb begin
        tgt = pulse_len;
        if (pulse_len < MIN_LEN) begin
            tgt = MIN_LEN;
        end else if (pulse_len > MAX_LEN) begin
            tgt = MAX_LEN;
        end
    end

    // Slew-limited width for the next frame
    always_comb begin
        if (tgt >= current_len) begin
            diff = {1'b0, tgt} - {1'b0, current_len};
        end else begin
            diff = {1'b0, current_len} - {1'b0, tgt};
        end
        next_len = tgt;
        if ((STEP_US != 0) && (diff > STEP_DIFF)) begin
            next_len = (tgt > current_len) ? (current_len + STEP_LEN)
                                           : (current_len - STEP_LEN);
        end
    end

    // Microsecond prescaler and frame position counter
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            prescaler <= '0;
            us_count  <= '0;
        end else begin
            prescaler <= us_tick ? '0 : (prescaler + PW'(1));
            if (us_tick) begin
                us_count <= (us_count == US_LAST) ? '0 : (us_count + CW'(1));
            end
        end
    end

    // Applied width and frame-start strobe, updated only at frame boundaries
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            current_len <= RST_LEN;
            frame_start <= 1'b0;
        end else begin
            frame_start <= boundary;
            if (boundary) begin
                current_len <= next_len;
            end
        end
    end

    // Registered PWM pin and target-reached flag
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            CONTROL_PIN <= 1'b0;
            at_target   <= 1'b0;
        end else begin
            CONTROL_PIN <= (32'(us_count) < 32'(current_len));
            at_target   <= (current_len == tgt);
        end
    end

endmodule

// File: tb/tb_servo_pwm_ramp.sv
// Scoreboard bench for servo_pwm_ramp: the stimulus process queues the
// expected frame results, monitors pop and compare at every frame_start.
module tb_servo_pwm_ramp;

    typedef struct {
        int len;
        int high;
        int at;
        int at_next;
    } exp_t;

    typedef struct {
        int len;
        int high;
    } exp0_t;

    // Expected per boundary (1..48) for the ramping instance:
    // applied width, high cycles of the frame just ended, at_target at the
    // frame_start cycle, at_target one cycle later.
    exp_t rows [0:47] = '{
        '{50, 200, 1, 0}, '{55, 200, 0, 0}, '{60, 220, 0, 0}, '{65, 240, 0, 0},
        '{70, 260, 0, 1}, '{70, 280, 1, 0}, '{65, 280, 0, 0}, '{60, 260, 0, 0},
        '{55, 240, 0, 0}, '{50, 220, 0, 0}, '{45, 200, 0, 0}, '{40, 180, 0, 0},
        '{35, 160, 0, 0}, '{30, 140, 0, 0}, '{25, 120, 0, 0}, '{20, 100, 0, 0},
        '{15,  80, 0, 0}, '{10,  60, 0, 1}, '{10,  40, 1, 0}, '{15,  40, 0, 0},
        '{20,  60, 0, 0}, '{25,  80, 0, 0}, '{30, 100, 0, 0}, '{35, 120, 0, 0},
        '{40, 140, 0, 0}, '{45, 160, 0, 0}, '{50, 180, 0, 0}, '{55, 200, 0, 0},
        '{60, 220, 0, 0}, '{65, 240, 0, 0}, '{70, 260, 0, 0}, '{75, 280, 0, 0},
        '{80, 300, 0, 0}, '{85, 320, 0, 0}, '{90, 340, 0, 1}, '{90, 360, 1, 1},
        '{90, 360, 1, 0}, '{85, 360, 0, 0}, '{80, 340, 0, 0}, '{75, 320, 0, 0},
        '{70, 300, 0, 0}, '{65, 280, 0, 0}, '{60, 260, 0, 0}, '{55, 240, 0, 0},
        '{50, 220, 0, 1}, '{50, 200, 1, 1}, '{55, 200, 0, 0}, '{60, 220, 0, 0}
    };

    // Expected per boundary (1..5) for the no-ramp instance
    exp0_t rows0 [0:4] = '{
        '{50, 200}, '{20, 200}, '{20, 80}, '{90, 80}, '{90, 360}
    };

    logic        CLK;
    logic        RESET_N;
    logic [15:0] pulse_len;
    logic [15:0] pulse_len0;
    logic        CONTROL_PIN, CONTROL_PIN0;
    logic [15:0] current_len, current_len0;
    logic        frame_start, frame_start0;
    logic        at_target, at_target0;
    logic        clk_en;

    exp_t  q[$];
    exp0_t q0[$];

    int n_total = 0;
    int n_pass  = 0;

    servo_pwm_ramp #(
        .CLK_MHZ (4),
        .FRAME_US(100),
        .MIN_US  (10),
        .MAX_US  (90),
        .STEP_US (5)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .pulse_len  (pulse_len),
        .CONTROL_PIN(CONTROL_PIN),
        .current_len(current_len),
        .frame_start(frame_start),
        .at_target  (at_target)
    );

    servo_pwm_ramp #(
        .CLK_MHZ (4),
        .FRAME_US(100),
        .MIN_US  (10),
        .MAX_US  (90),
        .STEP_US (0)
    ) dut0 (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .pulse_len  (pulse_len0),
        .CONTROL_PIN(CONTROL_PIN0),
        .current_len(current_len0),
        .frame_start(frame_start0),
        .at_target  (at_target0)
    );

    initial CLK = 1'b0;
    always #5 if (clk_en) CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s", name);
    endtask

    task automatic wait_fs(input int b);
        int k;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!frame_start && k < 1000);
        if (!frame_start) begin
            $display("FAIL frame_start_timeout: boundary %0d not seen within 1000 cycles", b);
            n_total++;
        end
    endtask

    // Monitor for the ramping instance
    initial begin : monitor
        int   high_cnt;
        int   period_cnt;
        bit   first;
        bit   pend;
        int   pend_at;
        exp_t e;
        high_cnt = 0; period_cnt = 0; first = 1'b1; pend = 1'b0; pend_at = 0;
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                high_cnt = 0; period_cnt = 0; first = 1'b1; pend = 1'b0;
            end else begin
                if (pend) begin
                    check("at_target_next_cycle", int'(at_target), pend_at);
                    pend = 1'b0;
                end
                if (frame_start) begin
                    if (q.size() == 0) begin
                        fail_now("unexpected_frame_start");
                    end else begin
                        e = q.pop_front();
                        check("current_len", int'(current_len), e.len);
                        check("high_cycles", high_cnt, e.high);
                        check("at_target_at_boundary", int'(at_target), e.at);
                        if (!first) check("frame_period", period_cnt, 400);
                        first   = 1'b0;
                        pend    = 1'b1;
                        pend_at = e.at_next;
                    end
                    high_cnt   = 0;
                    period_cnt = 0;
                end
                if (CONTROL_PIN) high_cnt++;
                period_cnt++;
            end
        end
    end

    // Monitor for the no-ramp instance
    initial begin : monitor0
        int    high_cnt;
        exp0_t e;
        high_cnt = 0;
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                high_cnt = 0;
            end else begin
                if (frame_start0 && q0.size() != 0) begin
                    e = q0.pop_front();
                    check("noramp_current_len", int'(current_len0), e.len);
                    check("noramp_high_cycles", high_cnt, e.high);
                end
                if (frame_start0) high_cnt = 0;
                if (CONTROL_PIN0) high_cnt++;
            end
        end
    end

    // Stimulus
    initial begin
        clk_en     = 1'b1;
        RESET_N    = 1'b0;
        pulse_len  = 16'd50;
        pulse_len0 = 16'd50;
        repeat (3) @(negedge CLK);

        check("reset_pin",         int'(CONTROL_PIN), 0);
        check("reset_current_len", int'(current_len), 50);
        check("reset_frame_start", int'(frame_start), 0);
        check("reset_at_target",   int'(at_target), 0);
        check("noramp_reset_len",  int'(current_len0), 50);

        q.push_back(rows[0]);
        q0.push_back(rows0[0]);
        RESET_N = 1'b1;

        @(negedge CLK);
        check("release_pin_high",   int'(CONTROL_PIN), 1);
        check("release_at_target",  int'(at_target), 1);
        check("release_no_fstart",  int'(frame_start), 0);

        for (int b = 1; b <= 48; b++) begin
            wait_fs(b);
            if (b < 48) q.push_back(rows[b]);
            if (b < 5)  q0.push_back(rows0[b]);
            case (b)
                1:  begin pulse_len = 16'd70; pulse_len0 = 16'd20; end
                3:  pulse_len0 = 16'd65535;
                6:  pulse_len = 16'd0;
                19: pulse_len = 16'd65535;
                37: pulse_len = 16'd50;
                46: begin
                        repeat (120) @(negedge CLK);
                        pulse_len = 16'd70;
                    end
                default: ;
            endcase
        end

        repeat (3) @(negedge CLK);
        check("scoreboard_drained",        q.size(), 0);
        check("noramp_scoreboard_drained", q0.size(), 0);

        // Asynchronous reset with the clock stopped mid-pulse
        check("pin_high_before_async_reset", int'(CONTROL_PIN), 1);
        clk_en = 1'b0;
        #3;
        RESET_N = 1'b0;
        #1;
        check("async_reset_pin",         int'(CONTROL_PIN), 0);
        check("async_reset_current_len", int'(current_len), 50);
        check("async_reset_frame_start", int'(frame_start), 0);
        check("async_reset_at_target",   int'(at_target), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
